channel_phase_gen: RTL

- Per-channel tone phase generator sitting directly upstream of the square-wave stage.
- Divides the system clock by a programmable note divider and advances an M-bit phase counter, exported as `period`.
- The downstream square stage uses `period[M-1]` as its square wave.
- Frequency changes are glitch-free: a new divider takes effect at a phase wrap unless a retrigger is requested.

---
 rtl/channel_phase_gen.sv | 70 +++++++
 1 files changed

// File: rtl/channel_phase_gen.sv
// channel_phase_gen: divides clk by a programmable note divider and advances an M-bit phase counter for the square stage.
module channel_phase_gen #(
    parameter int M = 6,
    parameter int D = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cfg_valid,
    output logic         o_cfg_ready,
    input  logic [D-1:0] i_cfg_div,
    input  logic         i_cfg_retrig,
    input  logic         i_gate,
    output logic [M-1:0] o_period,
    output logic         o_wrap,
    output logic         o_active
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t r_state, w_state_nxt;
    logic [D-1:0] r_div_cur, r_div_pend, r_cnt, w_div_eff, w_div_nxt, w_div_pend_nxt, w_cnt_nxt;
    logic [M-1:0] r_phase, w_phase_nxt;
    logic r_pend, r_wrap, w_xfer, w_retrig, w_load, w_step, w_wrap_step, w_run, w_apply;
    logic w_pend_nxt, w_wrap_nxt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_xfer      = i_cfg_valid && !r_pend;
        w_retrig    = w_xfer && i_cfg_retrig;
        w_load      = w_xfer && !i_cfg_retrig;
        w_div_eff   = w_retrig ? i_cfg_div : r_div_cur;
        w_state_nxt = (i_gate && w_div_eff != '0) ? RUN : IDLE;
    end
    // w_run: phase keeps counting; any retrigger, gate fall or IDLE cycle restarts it at 0
    always_comb begin
        w_step         = r_cnt == r_div_cur;
        w_wrap_step    = w_step && r_phase == '1;
        w_run          = r_state == RUN && w_state_nxt == RUN && !w_retrig;
        w_apply        = r_pend && (r_state == IDLE || (w_run && w_wrap_step));
        w_div_nxt      = w_retrig ? i_cfg_div : w_apply ? r_div_pend : r_div_cur;
        w_div_pend_nxt = w_load ? i_cfg_div : r_div_pend;
        w_pend_nxt     = w_load || (r_pend && !w_apply);
        w_cnt_nxt      = (!w_run || w_step) ? '0 : r_cnt + 1'b1;
        w_phase_nxt    = !w_run ? '0 : r_phase + M'(w_step);
        w_wrap_nxt     = w_run && w_wrap_step;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cur  <= '0;
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_div_cur  <= w_div_nxt;
            r_div_pend <= w_div_pend_nxt;
            r_pend     <= w_pend_nxt;
            r_cnt      <= w_cnt_nxt;
            r_phase    <= w_phase_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end
    always_comb begin
        o_active    = r_state == RUN;
        o_cfg_ready = !r_pend;
        o_period    = r_phase;
        o_wrap      = r_wrap;
    end
endmodule
